// File: rtl/clcd_pkg.sv
// Shared types and constants for the character-LCD controller.
package clcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_SETUP,
        ST_EHIGH,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_e;

    // One byte headed for the LCD bus together with its register select.
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    localparam logic [7:0] FUNC_SET = 8'h38;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] ENTRY    = 8'h06;

    localparam int unsigned INIT_LEN = 7;
    localparam int unsigned STEP_W   = 3;

    localparam int unsigned DEF_T_PWRUP = 750000;
    localparam int unsigned DEF_T_INIT1 = 205000;
    localparam int unsigned DEF_T_SU    = 4;
    localparam int unsigned DEF_T_EW    = 15;
    localparam int unsigned DEF_T_HOLD  = 4;
    localparam int unsigned DEF_T_EXEC  = 2500;
    localparam int unsigned DEF_T_LONG  = 100000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear display / return home (0x01..0x03) need the long execution wait.
    function automatic logic is_long_cmd(input lcd_byte_t b);
        return (!b.rs) && (b.data[7:2] == 6'd0) && (b.data != 8'd0);
    endfunction

endpackage

// File: rtl/clcd_init_rom.sv
// Power-up init sequence: step index to instruction byte plus last-step flag.
module clcd_init_rom
    import clcd_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    output logic [7:0]        init_byte,
    output logic              last
);

    // Table lookup of the init instruction for this step.
    always_comb begin
        init_byte = 8'h00;
        case (step)
            3'd0, 3'd1, 3'd2, 3'd3: init_byte = FUNC_SET;
            3'd4:                   init_byte = DISP_ON;
            3'd5:                   init_byte = CLEAR;
            3'd6:                   init_byte = ENTRY;
            default:                init_byte = 8'h00;
        endcase
        last = (step == STEP_W'(INIT_LEN - 1));
    end

endmodule

// File: rtl/clcd_ctrl.sv
// HD44780 write-only driver: autonomous init, byte commands, E-strobe timing.
module clcd_ctrl
    import clcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = DEF_T_PWRUP,
    parameter int unsigned T_INIT1 = DEF_T_INIT1,
    parameter int unsigned T_SU    = DEF_T_SU,
    parameter int unsigned T_EW    = DEF_T_EW,
    parameter int unsigned T_HOLD  = DEF_T_HOLD,
    parameter int unsigned T_EXEC  = DEF_T_EXEC,
    parameter int unsigned T_LONG  = DEF_T_LONG
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       init_done,
    input  logic       reinit,
    output logic       CLCD_RS,
    output logic       CLCD_RW,
    output logic       CLCD_E,
    output logic [7:0] CLCD_DQ
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_PWRUP, T_INIT1), max_u(T_SU, T_EW)),
                                          max_u(max_u(T_HOLD, T_EXEC), T_LONG));
    localparam int unsigned TW    = $clog2(T_MAX);

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              init_mode_q, init_mode_d;
    logic              pend_q, pend_d;
    lcd_byte_t         hold_q, hold_d;
    lcd_byte_t         bus_q, bus_d;
    logic              e_q, e_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    logic [7:0]        rom_byte;
    logic              rom_last;
    logic              timer_zero;
    logic [TW-1:0]     wait_load;

    clcd_init_rom u_rom (
        .step      (step_q),
        .init_byte (rom_byte),
        .last      (rom_last)
    );

    assign timer_zero = (timer_q == '0);

    // Execution wait that follows the strobe currently on the bus.
    assign wait_load = (init_mode_q && step_q == '0) ? TW'(T_INIT1 - 1) :
                       is_long_cmd(bus_q)            ? TW'(T_LONG - 1)  :
                                                       TW'(T_EXEC - 1);

    // Next-state, timer and output computation.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_zero ? timer_q : timer_q - TW'(1);
        step_d      = step_q;
        init_mode_d = init_mode_q;
        pend_d      = pend_q | (reinit & (state_q != ST_IDLE));
        hold_d      = hold_q;
        bus_d       = bus_q;
        e_d         = e_q;
        ready_d     = ready_q;
        done_d      = done_q;

        case (state_q)
            ST_PWRUP: begin
                if (timer_zero) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bus_d   = init_mode_q ? '{rs: 1'b0, data: rom_byte} : hold_q;
                timer_d = TW'(T_SU - 1);
                state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    e_d     = 1'b1;
                    timer_d = TW'(T_EW - 1);
                    state_d = ST_EHIGH;
                end
            end
            ST_EHIGH: begin
                if (timer_zero) begin
                    e_d     = 1'b0;
                    timer_d = TW'(T_HOLD - 1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    timer_d = wait_load;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_zero) begin
                    if (pend_q || reinit) begin
                        pend_d      = 1'b0;
                        init_mode_d = 1'b1;
                        step_d      = '0;
                        done_d      = 1'b0;
                        state_d     = ST_LOAD;
                    end else if (init_mode_q && !rom_last) begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = ST_LOAD;
                    end else begin
                        init_mode_d = 1'b0;
                        done_d      = 1'b1;
                        ready_d     = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (reinit) begin
                    init_mode_d = 1'b1;
                    step_d      = '0;
                    done_d      = 1'b0;
                    ready_d     = 1'b0;
                    state_d     = ST_LOAD;
                end else if (cmd_valid && ready_q) begin
                    hold_d  = '{rs: cmd_rs, data: cmd_data};
                    ready_d = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_PWRUP;
        endcase
    end

    // State and output registers; reset drops the strobe immediately.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= ST_PWRUP;
            timer_q     <= TW'(T_PWRUP);
            step_q      <= '0;
            init_mode_q <= 1'b1;
            pend_q      <= 1'b0;
            hold_q      <= '0;
            bus_q       <= '0;
            e_q         <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            step_q      <= step_d;
            init_mode_q <= init_mode_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            bus_q       <= bus_d;
            e_q         <= e_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = ready_q;
    assign init_done = done_q;
    assign CLCD_RS   = bus_q.rs;
    assign CLCD_DQ   = bus_q.data;
    assign CLCD_E    = e_q;
    assign CLCD_RW   = 1'b0;

endmodule

// File: tb/tb_clcd_ctrl.sv
// Scoreboard bench for clcd_ctrl with shortened timing.
module tb_clcd_ctrl;

    localparam int T_PWRUP = 20;
    localparam int T_INIT1 = 10;
    localparam int T_SU    = 2;
    localparam int T_EW    = 3;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 5;
    localparam int T_LONG  = 12;

    logic       clk = 1'b0;
    logic       nRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       reinit = 1'b0;
    logic       cmd_ready, init_done;
    logic       CLCD_RS, CLCD_RW, CLCD_E;
    logic [7:0] CLCD_DQ;

    clcd_ctrl #(
        .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_SU(T_SU), .T_EW(T_EW),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_LONG(T_LONG)
    ) dut (
        .clk(clk), .nRESET(nRESET),
        .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .init_done(init_done), .reinit(reinit),
        .CLCD_RS(CLCD_RS), .CLCD_RW(CLCD_RW), .CLCD_E(CLCD_E), .CLCD_DQ(CLCD_DQ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] exp_q[$];
    logic [7:0] init_seq [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    int  last_rise = 0, last_fall = 0, first_rise = 0, done_cyc = 0, rel = 0;
    bit  want_first = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference latency from accept edge to cmd_ready returning.
    function automatic int exp_lat(input logic rs, input logic [7:0] d);
        int w;
        w = (!rs && d >= 8'd1 && d <= 8'd3) ? T_LONG : T_EXEC;
        return 1 + T_SU + T_EW + T_HOLD + w;
    endfunction

    // Monitor: every E pulse must match the next expected byte and timing.
    bit         in_pulse = 1'b0;
    bit         done_prev = 1'b0;
    int         width = 0;
    logic [8:0] cap;
    logic [8:0] e_exp;
    always @(negedge clk) begin
        if (!nRESET) begin
            in_pulse  = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (CLCD_E && !in_pulse) begin
                in_pulse  = 1'b1;
                width     = 1;
                cap       = {CLCD_RS, CLCD_DQ};
                last_rise = cyc;
                if (want_first) begin
                    first_rise = cyc;
                    want_first = 1'b0;
                end
                chk("rw_low", int'(CLCD_RW), 0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL strobe_unexpected: got rs=%0d dq=0x%02h with nothing expected at cycle %0d",
                             CLCD_RS, CLCD_DQ, cyc);
                end else begin
                    e_exp = exp_q.pop_front();
                    chk("strobe_rs_dq", int'(cap), int'(e_exp));
                end
            end else if (CLCD_E) begin
                width++;
                chk("bus_stable_e_high", int'({CLCD_RS, CLCD_DQ}), int'(cap));
            end else if (in_pulse) begin
                in_pulse  = 1'b0;
                last_fall = cyc;
                chk("e_width", width, T_EW);
                chk("bus_held_after_e", int'({CLCD_RS, CLCD_DQ}), int'(cap));
            end
            if (init_done && !done_prev) done_cyc = cyc;
            done_prev = init_done;
        end
    end

    task automatic apply_reset();
        nRESET = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_e", int'(CLCD_E), 0);
        chk("rst_rs", int'(CLCD_RS), 0);
        chk("rst_rw", int'(CLCD_RW), 0);
        chk("rst_dq", int'(CLCD_DQ), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_done", int'(init_done), 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, init_seq[i]});
        want_first = 1'b1;
        nRESET     = 1'b1;
        rel        = cyc + 1;
    endtask

    task automatic check_pwrup();
        chk("pwrup_first_e", first_rise - rel, T_PWRUP + 1 + T_SU);
    endtask

    task automatic wait_init();
        int ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1;
                break;
            end
        end
        chk("init_done_seen", ok, 1);
        if (ok == 1) begin
            chk("init_done_timing", cyc - last_fall, T_HOLD + T_EXEC);
            chk("ready_with_done", int'(cmd_ready), 1);
            chk("init_strobes_all_seen", exp_q.size(), 0);
        end
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int acc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rs    = rs;
        cmd_data  = d;
        acc       = -1;
        for (int i = 0; i < 3000; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            chk("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back({rs, d});
        end
    endtask

    task automatic wait_ready(input int acc, input int lat);
        int ret;
        ret = -1;
        @(negedge clk);
        chk("ready_falls", int'(cmd_ready), 0);
        for (int i = 0; i < 3000; i++) begin
            if (cmd_ready) begin
                ret = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("ready_latency", ret - acc, lat);
        chk("e_rise_latency", last_rise - acc, 1 + T_SU);
    endtask

    task automatic wait_e(input logic level, output int at);
        at = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (CLCD_E == level) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("wait_e_timeout", 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc, at, rise;
        logic       rs;
        logic [7:0] d;

        #2;
        // Power-up init from reset.
        apply_reset();
        wait_init();
        check_pwrup();

        // Directed commands: data, long instruction, normal instruction.
        send(1'b1, 8'h41, acc); wait_ready(acc, exp_lat(1'b1, 8'h41));
        send(1'b0, 8'h01, acc); wait_ready(acc, exp_lat(1'b0, 8'h01));
        send(1'b0, 8'h80, acc); wait_ready(acc, exp_lat(1'b0, 8'h80));

        // Randomized command stream.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(3) == 0) begin
                rs = 1'b0;
                d  = 8'($urandom_range(3, 1));
            end else begin
                rs = 1'($urandom_range(1));
                d  = 8'($urandom);
            end
            send(rs, d, acc);
            wait_ready(acc, exp_lat(rs, d));
            repeat ($urandom_range(3)) @(negedge clk);
        end

        // Command held during init is taken on the first IDLE cycle only.
        apply_reset();
        send(1'b1, 8'h55, acc);
        chk("held_cmd_accept_cycle", acc - done_cyc, 1);
        wait_ready(acc, exp_lat(1'b1, 8'h55));
        chk("held_cmd_single_strobe", exp_q.size(), 0);
        check_pwrup();

        // reinit during EHIGH: strobe completes, init reruns without PWRUP.
        send(1'b1, 8'hA5, acc);
        wait_e(1'b1, at);
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, init_seq[i]});
        wait_e(1'b0, at);
        wait_e(1'b1, rise);
        chk("reinit_no_pwrup", rise - acc, exp_lat(1'b1, 8'hA5) + 1 + T_SU);
        chk("reinit_done_low", int'(init_done), 0);
        wait_init();

        // reinit and cmd_valid together in IDLE: reinit wins.
        @(negedge clk);
        reinit    = 1'b1;
        cmd_valid = 1'b1;
        cmd_rs    = 1'b1;
        cmd_data  = 8'h77;
        @(negedge clk);
        reinit    = 1'b0;
        cmd_valid = 1'b0;
        chk("idle_reinit_ready", int'(cmd_ready), 0);
        chk("idle_reinit_done", int'(init_done), 0);
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, init_seq[i]});
        wait_init();

        // Asynchronous reset while E is high.
        send(1'b0, 8'h0F, acc);
        wait_e(1'b1, at);
        #2;
        nRESET = 1'b0;
        #1;
        chk("async_rst_e", int'(CLCD_E), 0);
        chk("async_rst_rs", int'(CLCD_RS), 0);
        chk("async_rst_dq", int'(CLCD_DQ), 0);
        apply_reset();
        wait_init();
        check_pwrup();
        send(1'b1, 8'h30, acc); wait_ready(acc, exp_lat(1'b1, 8'h30));

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
